// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder family.
package cla_pkg;

  localparam int SLICE_W = 16;

  function automatic int slice_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla16_stage.sv
// Combinational 16-bit carry-lookahead slice: four 4-bit CLA blocks and a lookahead carry unit.
module cla16_stage
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] s,
  output logic               c_out,
  output logic               p,
  output logic               g
);

  logic [SLICE_W-1:0] h;
  logic [SLICE_W-1:0] t;
  logic [SLICE_W-1:0] gb;
  logic [SLICE_W-1:0] c;
  logic [3:0]         pn;
  logic [3:0]         gn;
  logic [4:0]         cn;

  // t (a|b) drives the carry chain so group P reads as "a carry-in would pass";
  // h (a^b) forms the sum bits.
  assign h  = a ^ b;
  assign t  = a | b;
  assign gb = a & b;

  for (genvar j = 0; j < 4; j++) begin : g_nib
    localparam int B = 4 * j;
    assign pn[j]  = &t[B +: 4];
    assign gn[j]  = gb[B+3] | (t[B+3] & gb[B+2]) | (t[B+3] & t[B+2] & gb[B+1])
                  | (t[B+3] & t[B+2] & t[B+1] & gb[B]);
    assign c[B]   = cn[j];
    assign c[B+1] = gb[B] | (t[B] & cn[j]);
    assign c[B+2] = gb[B+1] | (t[B+1] & gb[B]) | (t[B+1] & t[B] & cn[j]);
    assign c[B+3] = gb[B+2] | (t[B+2] & gb[B+1]) | (t[B+2] & t[B+1] & gb[B])
                  | (t[B+2] & t[B+1] & t[B] & cn[j]);
  end

  assign cn[0] = c_in;
  assign cn[1] = gn[0] | (pn[0] & c_in);
  assign cn[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & c_in);
  assign cn[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0])
               | (pn[2] & pn[1] & pn[0] & c_in);

  assign g     = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1])
               | (pn[3] & pn[2] & pn[1] & gn[0]);
  assign p     = &pn;
  assign cn[4] = g | (p & c_in);

  assign c_out = cn[4];
  assign s     = h ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: one 16-bit slice resolved per stage, carry registered between
// stages, single global enable driven by the output handshake.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter  int WIDTH  = 32,
  localparam int NSLICE = slice_count(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  s,
  output logic              cout,
  output logic              ovf,
  output logic [NSLICE-1:0] gout,
  output logic [NSLICE-1:0] pout
);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a positive multiple of 16");
  end

  logic                           en;
  logic [WIDTH-1:0]               a_in;
  logic [WIDTH-1:0]               b_in;
  logic                           c_in0;

  logic [NSLICE-1:0]              v_q;
  logic [NSLICE-1:0]              c_q;
  logic [NSLICE-1:0]              ovf_q;
  logic [NSLICE-1:0][WIDTH-1:0]   a_q;
  logic [NSLICE-1:0][WIDTH-1:0]   b_q;
  logic [NSLICE-1:0][WIDTH-1:0]   sum_q;
  logic [NSLICE-1:0][NSLICE-1:0]  g_q;
  logic [NSLICE-1:0][NSLICE-1:0]  p_q;
  logic                           unused_ok;

  assign en       = ~v_q[NSLICE-1] | out_ready;
  assign in_ready = en;

  // Bubbles enter as all-zero operands so idle stages (and the outputs) stay at zero.
  assign a_in  = in_valid ? a : '0;
  assign b_in  = in_valid ? (sub ? ~b : b) : '0;
  assign c_in0 = in_valid & (cin ^ sub);

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    localparam int LO = SLICE_W * k;

    logic [WIDTH-1:0]   a_src;
    logic [WIDTH-1:0]   b_src;
    logic [WIDTH-1:0]   sum_src;
    logic [NSLICE-1:0]  g_src;
    logic [NSLICE-1:0]  p_src;
    logic               c_src;
    logic               v_src;
    logic [WIDTH-1:0]   sum_nxt;
    logic [NSLICE-1:0]  g_nxt;
    logic [NSLICE-1:0]  p_nxt;
    logic [SLICE_W-1:0] ss;
    logic               sco;
    logic               sp;
    logic               sg;

    if (k == 0) begin : g_first
      assign a_src   = a_in;
      assign b_src   = b_in;
      assign c_src   = c_in0;
      assign v_src   = in_valid;
      assign sum_src = '0;
      assign g_src   = '0;
      assign p_src   = '0;
    end else begin : g_next
      assign a_src   = a_q[k-1];
      assign b_src   = b_q[k-1];
      assign c_src   = c_q[k-1];
      assign v_src   = v_q[k-1];
      assign sum_src = sum_q[k-1];
      assign g_src   = g_q[k-1];
      assign p_src   = p_q[k-1];
    end

    cla16_stage u_cla (
      .a     (a_src[LO +: SLICE_W]),
      .b     (b_src[LO +: SLICE_W]),
      .c_in  (c_src),
      .s     (ss),
      .c_out (sco),
      .p     (sp),
      .g     (sg)
    );

    always_comb begin
      sum_nxt                = sum_src;
      sum_nxt[LO +: SLICE_W] = ss;
      g_nxt                  = g_src;
      g_nxt[k]               = sg;
      p_nxt                  = p_src;
      p_nxt[k]               = sp;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        g_q[k]   <= '0;
        p_q[k]   <= '0;
      end else if (en) begin
        v_q[k]   <= v_src;
        c_q[k]   <= sco;
        // carry into the slice MSB recovered from its sum bit
        ovf_q[k] <= sco ^ (ss[SLICE_W-1] ^ a_src[LO+SLICE_W-1] ^ b_src[LO+SLICE_W-1]);
        a_q[k]   <= a_src;
        b_q[k]   <= b_src;
        sum_q[k] <= sum_nxt;
        g_q[k]   <= g_nxt;
        p_q[k]   <= p_nxt;
      end
    end
  end

  assign out_valid = v_q[NSLICE-1];
  assign s         = sum_q[NSLICE-1];
  assign cout      = c_q[NSLICE-1];
  assign ovf       = ovf_q[NSLICE-1];
  assign gout      = g_q[NSLICE-1];
  assign pout      = p_q[NSLICE-1];

  // Consumed operand slices and lower-stage overflow bits have no further reader.
  assign unused_ok = ^{a_q, b_q, ovf_q};

endmodule
